// File: rtl/fdce_toggle_monitor.sv
// Health monitor for a divide-by-2 FDCE toggle stage: detects rising edges of D,
// measures their spacing, locks after a run of good periods and flags faults.
module fdce_toggle_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 2,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             EN,
    input  logic             D,
    output logic             EDGE,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] EDGE_CNT,
    output logic             LOCKED,
    output logic             ERR
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] EXP_LO   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] EXP_HI   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQUIRE,
        S_TRACK,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t           state_q;
    logic             d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [MW-1:0]    match_cnt_q;
    logic [MW-1:0]    match_inc;
    logic             edge_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             locked_q;
    logic             err_q;

    logic rise;
    logic qual_rise;
    logic cnt_sat;
    logic period_ok;
    logic timeout;

    assign rise      = D & ~d_q;
    assign qual_rise = rise && (state_q != S_IDLE);
    assign cnt_sat   = (cnt_q == CNT_MAX);
    // A saturated count is an unknown (too long) period, never a match.
    assign period_ok = !cnt_sat && (cnt_q >= EXP_LO) && (cnt_q <= EXP_HI);
    assign timeout   = !rise && (cnt_q >= EXP_HI);
    assign match_inc = match_cnt_q + MW'(1);
    assign cnt_d     = rise ? CNT_W'(1) : (cnt_sat ? cnt_q : cnt_q + CNT_W'(1));

    always_ff @(posedge C) begin
        if (CLR) begin
            state_q     <= S_IDLE;
            d_q         <= 1'b0;
            cnt_q       <= '0;
            match_cnt_q <= '0;
            edge_q      <= 1'b0;
            period_q    <= '0;
            edge_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            d_q    <= D;
            cnt_q  <= cnt_d;
            edge_q <= qual_rise;
            if (qual_rise) begin
                edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                // The acquiring rise has no trustworthy predecessor to measure from.
                if (state_q != S_ACQUIRE) begin
                    period_q <= cnt_q;
                end
            end

            if (!EN) begin
                state_q     <= S_IDLE;
                match_cnt_q <= '0;
                locked_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_ACQUIRE;
                    end
                    S_ACQUIRE: begin
                        if (rise) begin
                            state_q     <= S_TRACK;
                            match_cnt_q <= '0;
                        end
                    end
                    S_TRACK: begin
                        if (rise) begin
                            if (period_ok) begin
                                match_cnt_q <= match_inc;
                                if (match_inc == LOCK_TGT) begin
                                    state_q  <= S_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                match_cnt_q <= '0;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if ((rise && !period_ok) || timeout) begin
                            state_q  <= S_FAULT;
                            locked_q <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
                    S_FAULT: begin
                        state_q <= S_FAULT;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign EDGE     = edge_q;
    assign PERIOD   = period_q;
    assign EDGE_CNT = edge_cnt_q;
    assign LOCKED   = locked_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_fdce_toggle_monitor.sv
// Bench for fdce_toggle_monitor: three configurations checked every cycle
// against a timestamp-based model, plus directed literal expectations.
module tb_fdce_toggle_monitor;

    localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_LOCKED = 3, M_FAULT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr[3];
    logic en[3];
    logic d[3];

    logic        o_edge[3];
    logic [15:0] o_period[3];
    logic [15:0] o_edge_cnt[3];
    logic        o_locked[3];
    logic        o_err[3];

    logic        e0, e1, e2, l0, l1, l2, r0, r1, r2;
    logic [15:0] p0, p1, c0, c1;
    logic [3:0]  p2, c2;

    fdce_toggle_monitor u0 (
        .C(clk), .CLR(clr[0]), .EN(en[0]), .D(d[0]),
        .EDGE(e0), .PERIOD(p0), .EDGE_CNT(c0), .LOCKED(l0), .ERR(r0)
    );

    fdce_toggle_monitor #(.CNT_W(16), .EXP_PERIOD(4), .TOL(1), .LOCK_COUNT(4)) u1 (
        .C(clk), .CLR(clr[1]), .EN(en[1]), .D(d[1]),
        .EDGE(e1), .PERIOD(p1), .EDGE_CNT(c1), .LOCKED(l1), .ERR(r1)
    );

    fdce_toggle_monitor #(.CNT_W(4)) u2 (
        .C(clk), .CLR(clr[2]), .EN(en[2]), .D(d[2]),
        .EDGE(e2), .PERIOD(p2), .EDGE_CNT(c2), .LOCKED(l2), .ERR(r2)
    );

    assign o_edge[0] = e0;  assign o_edge[1] = e1;  assign o_edge[2] = e2;
    assign o_period[0] = p0;  assign o_period[1] = p1;  assign o_period[2] = {12'd0, p2};
    assign o_edge_cnt[0] = c0;  assign o_edge_cnt[1] = c1;  assign o_edge_cnt[2] = {12'd0, c2};
    assign o_locked[0] = l0;  assign o_locked[1] = l1;  assign o_locked[2] = l2;
    assign o_err[0] = r0;  assign o_err[1] = r1;  assign o_err[2] = r2;

    int cfg_cw[3]  = '{16, 16, 4};
    int cfg_exp[3] = '{2, 4, 2};
    int cfg_tol[3] = '{0, 1, 0};
    int cfg_lc[3]  = '{4, 4, 4};

    int vectors     = 0;
    int miscompares = 0;

    // Model state: the cycle of the last rise replaces a running counter.
    int cyc = 0;
    int m_dprev[3], m_last[3], m_mode[3], m_match[3];
    int m_edge[3], m_period[3], m_edges[3], m_err[3];

    task automatic model_step(input int i);
        int maxv, el, dev;
        bit rise, ok;
        maxv = (1 << cfg_cw[i]) - 1;
        if (clr[i]) begin
            m_dprev[i] = 0; m_last[i] = cyc + 1; m_mode[i] = M_IDLE; m_match[i] = 0;
            m_edge[i] = 0; m_period[i] = 0; m_edges[i] = 0; m_err[i] = 0;
        end else begin
            el = cyc - m_last[i];
            if (el > maxv) el = maxv;
            rise = (d[i] == 1'b1) && (m_dprev[i] == 0);
            m_dprev[i] = int'(d[i]);
            m_edge[i] = (rise && m_mode[i] != M_IDLE) ? 1 : 0;
            if (m_edge[i] == 1) begin
                m_edges[i] = (m_edges[i] + 1) % (maxv + 1);
                if (m_mode[i] != M_ACQ) m_period[i] = el;
            end
            dev = (el > cfg_exp[i]) ? el - cfg_exp[i] : cfg_exp[i] - el;
            ok = (el < maxv) && (dev <= cfg_tol[i]);
            if (!en[i]) begin
                m_mode[i] = M_IDLE;
                m_match[i] = 0;
            end else if (m_mode[i] == M_IDLE) begin
                m_mode[i] = M_ACQ;
            end else if (m_mode[i] == M_ACQ) begin
                if (rise) begin m_mode[i] = M_TRACK; m_match[i] = 0; end
            end else if (m_mode[i] == M_TRACK) begin
                if (rise && ok) begin
                    m_match[i]++;
                    if (m_match[i] == cfg_lc[i]) m_mode[i] = M_LOCKED;
                end else if (rise) begin
                    m_match[i] = 0;
                end
            end else if (m_mode[i] == M_LOCKED) begin
                if ((rise && !ok) || (!rise && el >= cfg_exp[i] + cfg_tol[i])) begin
                    m_mode[i] = M_FAULT;
                    m_err[i] = 1;
                end
            end
            if (rise) m_last[i] = cyc;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
            cyc++;
            #1;
            for (int i = 0; i < 3; i++) begin
                int exp_locked;
                exp_locked = (m_mode[i] == M_LOCKED) ? 1 : 0;
                vectors++;
                if (int'(o_edge[i]) != m_edge[i] || int'(o_period[i]) != m_period[i] ||
                    int'(o_edge_cnt[i]) != m_edges[i] || int'(o_locked[i]) != exp_locked ||
                    int'(o_err[i]) != m_err[i]) begin
                    miscompares++;
                    $display("FAIL cycle%0d u%0d: got edge=%0d period=%0d edge_cnt=%0d locked=%0d err=%0d, expected %0d %0d %0d %0d %0d",
                             cyc, i, o_edge[i], o_period[i], o_edge_cnt[i], o_locked[i], o_err[i],
                             m_edge[i], m_period[i], m_edges[i], exp_locked, m_err[i]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rise_gap(input int i, input int g);
        d[i] = 1'b1;
        tick(1);
        d[i] = 1'b0;
        tick(g - 1);
    endtask

    task automatic toggle_until_lock(input int i, input int budget, output int ok);
        ok = 0;
        for (int k = 0; k < budget && ok == 0; k++) begin
            d[i] = ~d[i];
            tick(1);
            if (o_locked[i]) ok = 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok;
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b1; en[i] = 1'b0; d[i] = 1'b0;
        end

        // Reset held with EN and toggling D on u0.
        en[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d[0] = ~d[0];
            tick(1);
            check("reset_edge", int'(o_edge[0]), 0);
            check("reset_locked", int'(o_locked[0]), 0);
        end
        check("reset_edge_cnt", int'(o_edge_cnt[0]), 0);

        // Nominal divide-by-2 stimulus locks on the 5th counted rise.
        clr[0] = 1'b0;
        toggle_until_lock(0, 60, ok);
        check("nominal_lock_reached", ok, 1);
        check("nominal_lock_edge_cnt", int'(o_edge_cnt[0]), 5);
        check("nominal_period", int'(o_period[0]), 2);
        check("nominal_edge_at_lock", int'(o_edge[0]), 1);
        for (int k = 0; k < 1000; k++) begin
            d[0] = ~d[0];
            tick(1);
        end
        check("nominal_err_1000", int'(o_err[0]), 0);
        check("nominal_still_locked", int'(o_locked[0]), 1);

        // Stall: D frozen after lock.
        tick(4);
        check("stall_err", int'(o_err[0]), 1);
        check("stall_locked", int'(o_locked[0]), 0);

        // Resume, re-enable, relock with ERR still sticky.
        en[0] = 1'b0;
        d[0] = ~d[0]; tick(1);
        d[0] = ~d[0]; tick(1);
        check("disabled_locked", int'(o_locked[0]), 0);
        en[0] = 1'b1;
        toggle_until_lock(0, 60, ok);
        check("relock_reached", ok, 1);
        check("relock_err_sticky", int'(o_err[0]), 1);

        clr[0] = 1'b1;
        tick(1);
        check("clr_err", int'(o_err[0]), 0);
        check("clr_edge_cnt", int'(o_edge_cnt[0]), 0);
        check("clr_period", int'(o_period[0]), 0);
        check("clr_locked", int'(o_locked[0]), 0);

        // Wrong period: rises every 4 cycles against an expected 2.
        clr[0] = 1'b0;
        d[0] = 1'b0;
        tick(1);
        for (int k = 0; k < 10; k++) rise_gap(0, 4);
        check("wrong_period", int'(o_period[0]), 4);
        check("wrong_locked", int'(o_locked[0]), 0);
        check("wrong_err", int'(o_err[0]), 0);
        en[0] = 1'b0;

        // Tolerance: periods 3,5,4,3 lock, then a late edge times out.
        clr[1] = 1'b0; en[1] = 1'b1; d[1] = 1'b0;
        tick(2);
        rise_gap(1, 3);
        rise_gap(1, 5);
        rise_gap(1, 4);
        rise_gap(1, 3);
        check("tol_not_yet_locked", int'(o_locked[1]), 0);
        d[1] = 1'b1; tick(1);
        check("tol_locked", int'(o_locked[1]), 1);
        check("tol_period", int'(o_period[1]), 3);
        d[1] = 1'b0; tick(4);
        check("tol_err_before_timeout", int'(o_err[1]), 0);
        tick(1);
        check("tol_timeout_err", int'(o_err[1]), 1);
        check("tol_timeout_locked", int'(o_locked[1]), 0);
        d[1] = 1'b1; tick(1);
        check("tol_late_edge", int'(o_edge[1]), 1);
        d[1] = 1'b0; tick(1);
        en[1] = 1'b0;

        // Saturation with a 4-bit counter.
        clr[2] = 1'b0; en[2] = 1'b1; d[2] = 1'b0;
        tick(2);
        rise_gap(2, 2);
        rise_gap(2, 2);
        tick(40);
        d[2] = 1'b1; tick(1);
        check("sat_period", int'(o_period[2]), 15);
        check("sat_edge", int'(o_edge[2]), 1);
        d[2] = 1'b0; tick(1);
        for (int k = 0; k < 3; k++) rise_gap(2, 2);
        check("sat_match_cleared", int'(o_locked[2]), 0);
        d[2] = 1'b1; tick(1);
        check("sat_relock", int'(o_locked[2]), 1);
        d[2] = 1'b0; tick(1);

        // Edge counter wrap: 17 rises on a 4-bit counter.
        clr[2] = 1'b1; tick(1);
        clr[2] = 1'b0; tick(1);
        for (int k = 0; k < 17; k++) rise_gap(2, 2);
        check("wrap_edge_cnt", int'(o_edge_cnt[2]), 1);
        check("wrap_err", int'(o_err[2]), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
